// File: rtl/issue_stage_sb.sv
// Issue stage: regfile, busy-bit scoreboard, EX/WB forwarding.
// Holds a decoded instruction until its operands resolve, then issues it.
module issue_stage_sb #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int AW    = $clog2(NREG),
  parameter int IMMW  = 32,
  parameter int CTRLW = 24
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic [AW-1:0]    rd,
  input  logic             we,
  input  logic [1:0]       bsel,
  input  logic [IMMW-1:0]  imm,
  input  logic [4:0]       shamt,
  input  logic [XLEN-1:0]  pc,
  input  logic [CTRLW-1:0] ctrl,
  input  logic             ex_valid,
  input  logic [AW-1:0]    ex_rd,
  input  logic [XLEN-1:0]  ex_data,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  op_a,
  output logic [XLEN-1:0]  op_b,
  output logic [AW-1:0]    rd_o,
  output logic             we_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [CTRLW-1:0] ctrl_o,
  output logic             stall
);

  logic [XLEN-1:0]  r_rf [NREG];
  logic [NREG-1:0]  r_busy;
  logic             r_valid;
  logic             r_we;
  logic [AW-1:0]    r_rd;
  logic [XLEN-1:0]  r_opa;
  logic [XLEN-1:0]  r_opb;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_imm;
  logic [CTRLW-1:0] r_ctrl;

  logic [AW-1:0]    w_src [2];
  logic             w_use [2];
  logic [XLEN-1:0]  w_val [2];
  logic             w_ok  [2];
  logic [XLEN-1:0]  w_imm;
  logic [XLEN-1:0]  w_opb;
  logic             w_waw;
  logic             w_can_load;
  logic             w_fire;
  logic             w_kill;
  logic [NREG-1:0]  w_busy_nxt;

  if (IMMW >= XLEN) begin : g_trunc
    assign w_imm = imm[XLEN-1:0];
  end else begin : g_sext
    assign w_imm = {{(XLEN-IMMW){imm[IMMW-1]}}, imm};
  end

  assign w_src[0] = rs1;
  assign w_src[1] = rs2;
  assign w_use[0] = use_rs1;
  assign w_use[1] = use_rs2;

  // x0 first, then EX, then WB, then the regfile if not busy
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      w_val[j] = r_rf[w_src[j]];
      w_ok[j]  = !r_busy[w_src[j]];
      if (w_src[j] == '0) begin
        w_val[j] = '0;
        w_ok[j]  = 1'b1;
      end else if (ex_valid && ex_rd == w_src[j]) begin
        w_val[j] = ex_data;
        w_ok[j]  = 1'b1;
      end else if (wb_we && wb_rd == w_src[j]) begin
        w_val[j] = wb_data;
        w_ok[j]  = 1'b1;
      end
      if (!w_use[j]) w_ok[j] = 1'b1;
    end
  end

  always_comb begin
    w_opb = w_val[1];
    unique case (1'b1)
      bsel == 2'b01: w_opb = w_imm;
      bsel == 2'b10: w_opb = XLEN'(shamt);
      default:       w_opb = w_val[1];
    endcase
  end

  assign w_waw = we && rd != '0 && r_busy[rd]
              && !(wb_we && wb_rd == rd);
  assign stall = in_valid
              && (!w_ok[0] || !w_ok[1] || w_waw);
  assign w_can_load = !r_valid || out_ready;
  assign in_ready = w_can_load && !stall && !flush;
  assign w_fire = in_valid && in_ready;
  assign w_kill = flush && r_valid && r_we
               && r_rd != '0;

  // clears first, so a same-cycle set wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_we) w_busy_nxt[wb_rd] = 1'b0;
    if (w_kill) w_busy_nxt[r_rd] = 1'b0;
    if (w_fire && we && rd != '0)
      w_busy_nxt[rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NREG; i++)
        r_rf[i] <= '0;
    end else if (wb_we && wb_rd != '0) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_rd    <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_pc    <= '0;
      r_imm   <= '0;
      r_ctrl  <= '0;
    end else if (w_fire) begin
      r_valid <= 1'b1;
      r_we    <= we;
      r_rd    <= rd;
      r_opa   <= w_val[0];
      r_opb   <= w_opb;
      r_pc    <= pc;
      r_imm   <= w_imm;
      r_ctrl  <= ctrl;
    end else if (w_can_load || flush) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_rd    <= '0;
    end
  end

  assign out_valid = r_valid;
  assign we_o      = r_we;
  assign rd_o      = r_rd;
  assign op_a      = r_opa;
  assign op_b      = r_opb;
  assign pc_o      = r_pc;
  assign imm_o     = r_imm;
  assign ctrl_o    = r_ctrl;

endmodule

// File: tb/tb_issue_stage_sb.sv
// Bench for issue_stage_sb: directed scenarios plus random traffic
// checked every cycle against a behavioural model.
module tb_issue_stage_sb;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int IMMW  = 12;
  localparam int CTRLW = 24;

  logic clk = 1'b0;
  logic nrst;
  logic in_valid, in_ready;
  logic [AW-1:0] rs1, rs2, rd;
  logic use_rs1, use_rs2, we;
  logic [1:0] bsel;
  logic [IMMW-1:0] imm;
  logic [4:0] shamt;
  logic [XLEN-1:0] pc;
  logic [CTRLW-1:0] ctrl;
  logic ex_valid;
  logic [AW-1:0] ex_rd;
  logic [XLEN-1:0] ex_data;
  logic wb_we;
  logic [AW-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic flush;
  logic out_valid, out_ready;
  logic [XLEN-1:0] op_a, op_b, pc_o, imm_o;
  logic [AW-1:0] rd_o;
  logic we_o, stall;
  logic [CTRLW-1:0] ctrl_o;

  always #5 clk = ~clk;

  issue_stage_sb #(
    .XLEN(XLEN), .NREG(NREG), .AW(AW),
    .IMMW(IMMW), .CTRLW(CTRLW)
  ) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2),
    .use_rs1(use_rs1), .use_rs2(use_rs2),
    .rd(rd), .we(we), .bsel(bsel),
    .imm(imm), .shamt(shamt), .pc(pc), .ctrl(ctrl),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b), .rd_o(rd_o), .we_o(we_o),
    .pc_o(pc_o), .imm_o(imm_o), .ctrl_o(ctrl_o),
    .stall(stall)
  );

  int nvec = 0;
  int nerr = 0;

  logic [XLEN-1:0]  m_rf [NREG];
  bit               m_busy [NREG];
  logic             m_ov, m_we;
  logic [AW-1:0]    m_rd;
  logic [XLEN-1:0]  m_opa, m_opb, m_pc, m_imm;
  logic [CTRLW-1:0] m_ctrl;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] mval(input logic [AW-1:0] s);
    if (s == 0) return '0;
    if (ex_valid && ex_rd == s) return ex_data;
    if (wb_we && wb_rd == s) return wb_data;
    return m_rf[s];
  endfunction

  function automatic bit mok(input logic [AW-1:0] s, input logic u);
    if (!u || s == 0) return 1'b1;
    if (ex_valid && ex_rd == s) return 1'b1;
    if (wb_we && wb_rd == s) return 1'b1;
    return !m_busy[s];
  endfunction

  function automatic bit mstall();
    bit waw;
    waw = we && rd != 0 && m_busy[rd] && !(wb_we && wb_rd == rd);
    return in_valid && (!mok(rs1, use_rs1) || !mok(rs2, use_rs2) || waw);
  endfunction

  function automatic logic [XLEN-1:0] msext();
    logic signed [XLEN-1:0] si;
    si = $signed(imm);
    return si;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_rf[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_ov = 0; m_we = 0; m_rd = '0;
    m_opa = '0; m_opb = '0; m_pc = '0; m_imm = '0; m_ctrl = '0;
  endtask

  task automatic compare();
    bit cl;
    cl = !m_ov || out_ready;
    chk("in_ready", in_ready, cl && !mstall() && !flush);
    chk("stall", stall, mstall());
    chk("out_valid", out_valid, m_ov);
    chk("we_o", we_o, m_we);
    chk("rd_o", rd_o, m_rd);
    if (m_ov) begin
      chk("op_a", op_a, m_opa);
      chk("op_b", op_b, m_opb);
      chk("pc_o", pc_o, m_pc);
      chk("imm_o", imm_o, m_imm);
      chk("ctrl_o", ctrl_o, m_ctrl);
    end
  endtask

  task automatic model_step();
    bit cl, fire;
    logic [XLEN-1:0] a, b;
    cl = !m_ov || out_ready;
    fire = in_valid && cl && !mstall() && !flush;
    a = mval(rs1);
    case (bsel)
      2'b01:   b = msext();
      2'b10:   b = {27'b0, shamt};
      default: b = mval(rs2);
    endcase
    if (wb_we) m_busy[wb_rd] = 1'b0;
    if (flush && m_ov && m_we && m_rd != 0) m_busy[m_rd] = 1'b0;
    if (fire && we && rd != 0) m_busy[rd] = 1'b1;
    if (fire) begin
      m_ov = 1; m_we = we; m_rd = rd;
      m_opa = a; m_opb = b; m_pc = pc;
      m_imm = msext(); m_ctrl = ctrl;
    end else if (cl || flush) begin
      m_ov = 0; m_we = 0; m_rd = '0;
    end
    if (wb_we && wb_rd != 0) m_rf[wb_rd] = wb_data;
  endtask

  task automatic tick();
    compare();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; rs1 = 0; rs2 = 0; use_rs1 = 0; use_rs2 = 0;
    rd = 0; we = 0; bsel = 0; imm = 0; shamt = 0; pc = 0; ctrl = 0;
    ex_valid = 0; ex_rd = 0; ex_data = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic instr(input logic [AW-1:0] a, input logic ua,
                       input logic [AW-1:0] b, input logic ub,
                       input logic [AW-1:0] d, input logic w,
                       input logic [1:0] bs, input logic [IMMW-1:0] im,
                       input logic [XLEN-1:0] p);
    in_valid = 1; rs1 = a; use_rs1 = ua; rs2 = b; use_rs2 = ub;
    rd = d; we = w; bsel = bs; imm = im; pc = p;
    ctrl = p[CTRLW-1:0] ^ 24'h5A5A5A;
  endtask

  initial begin
    idle();
    nrst = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_rd_o", rd_o, 0);
    chk("rst_we_o", we_o, 0);
    chk("rst_pc_o", pc_o, 0);
    chk("rst_imm_o", imm_o, 0);
    chk("rst_ctrl_o", ctrl_o, 0);
    @(negedge clk);
    nrst = 1;

    // addi x5 then add x6,x5,x5 forwarded from EX
    instr(0, 1, 0, 0, 5, 1, 2'b01, 12'd7, 32'h100);
    #1 tick();
    chk("t2_opb_imm", op_b, 32'd7);
    chk("t2_rd_o", rd_o, 5);
    instr(5, 1, 5, 1, 6, 1, 2'b00, 0, 32'h104);
    ex_valid = 1; ex_rd = 5; ex_data = 32'h10;
    #1;
    chk("t2_stall", stall, 0);
    chk("t2_in_ready", in_ready, 1);
    tick();
    chk("t2_op_a", op_a, 32'h10);
    chk("t2_op_b", op_b, 32'h10);
    chk("t2_out_valid", out_valid, 1);

    // async reset with a valid output and busy x5
    idle();
    nrst = 0;
    #1;
    chk("t1_out_valid", out_valid, 0);
    model_reset();
    @(negedge clk);
    nrst = 1;
    instr(5, 1, 5, 1, 5, 1, 2'b00, 0, 32'h200);
    #1;
    chk("t1_stall", stall, 0);
    chk("t1_in_ready", in_ready, 1);
    tick();

    // load-use on x7 resolved by write-back
    idle();
    instr(0, 1, 0, 0, 7, 1, 2'b00, 0, 32'h300);
    #1 tick();
    instr(7, 1, 0, 0, 8, 1, 2'b00, 0, 32'h304);
    #1;
    chk("t3_stall", stall, 1);
    chk("t3_in_ready", in_ready, 0);
    tick();
    #1 tick();
    wb_we = 1; wb_rd = 7; wb_data = 32'hDEAD;
    #1;
    chk("t3_wb_stall", stall, 0);
    chk("t3_wb_in_ready", in_ready, 1);
    tick();
    chk("t3_op_a", op_a, 32'hDEAD);
    wb_we = 0;
    instr(7, 1, 0, 0, 0, 0, 2'b00, 0, 32'h308);
    #1;
    chk("t3_x7_free", stall, 0);
    tick();
    chk("t3_rf_read", op_a, 32'hDEAD);

    // output back-pressure
    instr(0, 1, 0, 0, 10, 1, 2'b01, 12'h800, 32'h400);
    #1 tick();
    chk("t4_imm_sext", imm_o, 32'hFFFF_F800);
    out_ready = 0;
    instr(0, 1, 0, 0, 11, 1, 2'b00, 0, 32'h404);
    repeat (3) begin
      #1;
      chk("t4_hold_ready", in_ready, 0);
      chk("t4_hold_pc", pc_o, 32'h400);
      tick();
    end
    out_ready = 1;
    #1;
    chk("t4_release", in_ready, 1);
    tick();
    chk("t4_next_pc", pc_o, 32'h404);

    // flush releases the busy bit of the killed instruction
    instr(0, 1, 0, 0, 9, 1, 2'b00, 0, 32'h500);
    #1 tick();
    idle();
    flush = 1;
    #1;
    chk("t5_flush_ready", in_ready, 0);
    tick();
    chk("t5_out_valid", out_valid, 0);
    idle();
    instr(9, 1, 0, 0, 12, 1, 2'b00, 0, 32'h504);
    #1;
    chk("t5_stall", stall, 0);
    tick();
    chk("t5_op_a", op_a, 32'h0);

    // x0 as destination and as source during a wb to x0
    idle();
    instr(0, 1, 0, 0, 0, 1, 2'b00, 0, 32'h600);
    wb_we = 1; wb_rd = 0; wb_data = 32'hFFFF;
    #1;
    chk("t6_stall", stall, 0);
    tick();
    chk("t6_op_a", op_a, 32'h0);
    wb_we = 0;
    instr(0, 0, 0, 0, 0, 1, 2'b00, 0, 32'h604);
    #1;
    chk("t6_no_waw", stall, 0);
    tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        nrst = 0;
        #1;
        chk("rnd_rst", out_valid, 0);
        model_reset();
        @(negedge clk);
        nrst = 1;
      end
      in_valid  = ($urandom_range(0, 9) < 7);
      rs1       = AW'($urandom_range(0, 7));
      rs2       = AW'($urandom_range(0, 7));
      use_rs1   = 1'($urandom);
      use_rs2   = 1'($urandom);
      rd        = AW'($urandom_range(0, 7));
      we        = 1'($urandom);
      bsel      = 2'($urandom);
      imm       = IMMW'($urandom);
      shamt     = 5'($urandom);
      pc        = $urandom;
      ctrl      = CTRLW'($urandom);
      ex_valid  = ($urandom_range(0, 9) < 3);
      ex_rd     = AW'($urandom_range(0, 7));
      ex_data   = $urandom;
      wb_we     = ($urandom_range(0, 9) < 4);
      wb_rd     = AW'($urandom_range(0, 7));
      wb_data   = $urandom;
      flush     = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1 tick();
    end

    idle();
    #1 tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/issue_stage_sb.md
Name: issue_stage_sb

Overview:
Parametrised successor issue stage. It combines the register file, a per-register busy-bit scoreboard and two-source operand forwarding (EX result, write-back) with a valid/ready handshake on both sides. It sits between decode and execute. It holds a decoded instruction until its operands are available, then issues one instruction per cycle into an output pipe register. It also supports flush on taken branch/jump.

Parameters:
XLEN, 32, data/operand width
NREG, 32, architectural registers (x0 hard-wired zero)
AW, $clog2(NREG), register address width
IMMW, 32, immediate width (sign-extended to XLEN when narrower)
CTRLW, 24, opaque control bundle passed through (alu_fn, mem_op, m_op, j/jr, etc.)

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
in_valid  in  1  decoded instruction present
in_ready  out  1  issue stage accepts instruction this cycle
rs1, rs2  in  AW  source addresses
use_rs1, use_rs2  in  1  instruction reads rs1/rs2
rd  in  AW  destination address
we  in  1  instruction writes rd
bsel  in  2  op_b select: 00 reg, 01 imm, 10 shamt, 11 reg
imm  in  IMMW  immediate
shamt  in  5  shift amount
pc  in  XLEN  instruction pc
ctrl  in  CTRLW  pass-through control
ex_valid  in  1  EX result valid this cycle
ex_rd  in  AW  EX result destination
ex_data  in  XLEN  EX result
wb_we  in  1  write-back enable
wb_rd  in  AW  write-back address
wb_data  in  XLEN  write-back data
flush  in  1  kill instruction at input and in output register
out_valid  out  1  issued instruction valid
out_ready  in  1  execute accepts
op_a, op_b  out  XLEN  resolved operands
rd_o  out  AW  destination
we_o  out  1  write enable (0 when out_valid=0)
pc_o  out  XLEN  pc
imm_o  out  XLEN  sign-extended immediate
ctrl_o  out  CTRLW  control
stall  out  1  hazard stall indicator

Behaviour:
- Reset (nrst=0, async): out_valid=0; op_a, op_b, rd_o, we_o, pc_o, imm_o, ctrl_o = 0; all busy bits = 0; all regfile entries = 0.
- Regfile: NREG x XLEN, synchronous write on wb_we when wb_rd!=0. Combinational read. x0 always reads 0.
- Source resolution per used source s (s!=0), first match wins:
  1. ex_valid && ex_rd==s → ex_data
  2. wb_we && wb_rd==s → wb_data
  3. busy[s]=0 → regfile
  4. otherwise unresolved.
  Unused sources and x0 are always resolved.
- WAW hazard: we && rd!=0 && busy[rd] && !(wb_we && wb_rd==rd).
- stall = in_valid && (any used source unresolved || WAW). stall is reported independent of out_ready.
- can_load = !out_valid || out_ready. in_ready = can_load && !stall && !flush.
- fire = in_valid && in_ready. On fire, next cycle:
  - out_valid=1;
  - op_a = resolved rs1 value;
  - op_b = resolved rs2 value (bsel 00/11), sign-extended imm (01), or zero-extended shamt (10);
  - all other outputs are registered copies.
- If can_load && !fire: out_valid becomes 0 (bubble). we_o=0 and rd_o=0 in that case.
- If !can_load: output register holds all values.
- Latency: one cycle from fire to out_valid.
- Scoreboard:
  - Set busy[rd] on fire when we && rd!=0.
  - Clear busy[wb_rd] on wb_we.
  - Simultaneous set and clear on the same register: set wins.
  - ex_valid does not clear busy.
- flush:
  - Next cycle out_valid=0.
  - If the output register holds a valid instruction with we_o && rd_o!=0, clear busy[rd_o].
  - No fire occurs in a flush cycle.
  - Flush overrides out_ready hold.
- Write-through: a wb write and a same-cycle read of the same register returns wb_data via forwarding rule 2.

Test Plan:
1. Reset mid-operation with out_valid=1 and busy[5]=1 → next cycle out_valid=0, busy all 0, in_ready=1.
2. Issue addi x5 (imm=7), then add x6,x5,x5 with ex_valid=1, ex_rd=5, ex_data=0x10 → second issues back-to-back with op_a=op_b=0x10, stall=0.
3. Issue lw x7, then use x7 with no ex match → stall=1 and in_ready=0 until wb_we=1, wb_rd=7, wb_data=0xDEAD; in that cycle the instruction fires with op_a=0xDEAD; busy[7] cleared.
4. out_ready=0 for 3 cycles with out_valid=1 → outputs stable, in_ready=0; on out_ready=1 the next instruction loads the following cycle.
5. flush while output holds we_o=1, rd_o=9 → out_valid=0 next cycle, busy[9]=0; a dependent on x9 issues without stall reading the regfile value.
6. Instruction writing x0, and a read of x0 while wb_rd=0 with wb_we=1 and wb_data=0xFFFF → no busy set, op_a=0, no stall.
